// File: rtl/video_dsm_dac.sv
// video_dsm_dac: 1st/2nd-order delta-sigma DAC for a 10-bit composite video stream
//   CK_i      system clock, rising edge
//   XRST_i    synchronous active-low reset
//   CK_EE_i   sample-capture enable for VIDEOs_i
//   CLR_i     synchronous clear of integrators, DAC bit and overflow flag
//   VIDEOs_i  unsigned composite sample
//   DAC_o     pulse-density output bit
//   OVF_o     sticky integrator-saturation flag
//   SMPLs_o   currently held sample
module video_dsm_dac #(
  parameter int C_W     = 10,
  parameter int C_ORDER = 2,
  parameter int C_DITH  = 0
) (
  input  logic           CK_i,
  input  logic           XRST_i,
  input  logic           CK_EE_i,
  input  logic           CLR_i,
  input  logic [C_W-1:0] VIDEOs_i,
  output logic           DAC_o,
  output logic           OVF_o,
  output logic [C_W-1:0] SMPLs_o
);
  localparam int W1 = C_W + 3;
  localparam int W2 = C_W + 6;
  // Common arithmetic width, one bit wider than the widest integrator so sums never wrap.
  localparam int WW = W2 + 1;
  localparam bit ORD2 = C_ORDER != 1;
  localparam logic signed [WW-1:0] HALF = {{(WW-C_W){1'b0}}, 1'b1, {(C_W-1){1'b0}}};
  localparam logic signed [WW-1:0] MAX1 = {{(WW-W1+1){1'b0}}, {(W1-1){1'b1}}};
  localparam logic signed [WW-1:0] MIN1 = {{(WW-W1+1){1'b1}}, {(W1-1){1'b0}}};
  localparam logic signed [WW-1:0] MAX2 = {{(WW-W2+1){1'b0}}, {(W2-1){1'b1}}};
  localparam logic signed [WW-1:0] MIN2 = {{(WW-W2+1){1'b1}}, {(W2-1){1'b0}}};
  logic signed [W1-1:0] i1;
  logic signed [W2-1:0] i2;
  logic [15:0] lfsr;
  logic signed [WW-1:0] xs, fb, a1, c1, a2, c2, th;
  logic q;
  always_comb begin
    xs = $signed({{(WW-C_W){1'b0}}, SMPLs_o}) - HALF;
    fb = DAC_o ? HALF : -HALF;
    a1 = {{(WW-W1){i1[W1-1]}}, i1} + xs - fb;
    c1 = a1 > MAX1 ? MAX1 : a1 < MIN1 ? MIN1 : a1;
    // The second stage integrates the already-clipped first-stage value.
    a2 = {{(WW-W2){i2[W2-1]}}, i2} + c1 - fb;
    c2 = a2 > MAX2 ? MAX2 : a2 < MIN2 ? MIN2 : a2;
    // Dither lowers the threshold to -1 on LFSR LSB, i.e. an LSB-sized offset.
    th = {WW{C_DITH == 1 && lfsr[0]}};
    q = (ORD2 ? c2 : c1) >= th;
  end
  always_ff @(posedge CK_i) begin
    if (!XRST_i) begin
      SMPLs_o <= '0;
      i1 <= '0;
      i2 <= '0;
      DAC_o <= 1'b0;
      OVF_o <= 1'b0;
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      if (CK_EE_i) SMPLs_o <= VIDEOs_i;
      if (CLR_i) begin
        i1 <= '0;
        i2 <= '0;
        DAC_o <= 1'b0;
        OVF_o <= 1'b0;
      end else begin
        i1 <= c1[W1-1:0];
        i2 <= ORD2 ? c2[W2-1:0] : '0;
        DAC_o <= q;
        OVF_o <= OVF_o | (c1 != a1) | (ORD2 && c2 != a2);
      end
    end
  end
endmodule

// File: tb/tb_video_dsm_dac.sv
// tb_video_dsm_dac: directed self-checking bench for first- and second-order video_dsm_dac
module tb_video_dsm_dac;
  logic clk = 1'b0;
  logic xrst, ck_ee, clr;
  logic [9:0] video;
  logic dac1, ovf1, dac2, ovf2;
  logic [9:0] smpl1, smpl2;
  int n_vec = 0;
  int n_err = 0;
  int cnt1, cnt2;
  bit s1_o1[10] = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
  bit s1_o2[10] = '{1, 0, 1, 0, 0, 1, 1, 0, 0, 1};

  always #5 clk = ~clk;

  video_dsm_dac #(.C_W(10), .C_ORDER(1), .C_DITH(0)) u1 (
    .CK_i(clk), .XRST_i(xrst), .CK_EE_i(ck_ee), .CLR_i(clr),
    .VIDEOs_i(video), .DAC_o(dac1), .OVF_o(ovf1), .SMPLs_o(smpl1));

  video_dsm_dac #(.C_W(10), .C_ORDER(2), .C_DITH(0)) u2 (
    .CK_i(clk), .XRST_i(xrst), .CK_EE_i(ck_ee), .CLR_i(clr),
    .VIDEOs_i(video), .DAC_o(dac2), .OVF_o(ovf2), .SMPLs_o(smpl2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset with enable and clear asserted: reset must win.
    xrst = 1'b0; ck_ee = 1'b1; clr = 1'b1; video = 10'd700;
    tick(); tick();
    chk("rst_smpl", smpl1, 0);
    chk("rst_dac", dac2, 0);
    chk("rst_ovf", ovf2, 0);
    chk("rst_i2", u2.i2, 0);
    chk("rst_lfsr", u2.lfsr, 16'hACE1);
    // Mid-scale input: first edge still sees the reset sample 0.
    xrst = 1'b1; clr = 1'b0; video = 10'd512;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("s1_o1_%0d", k), dac1, s1_o1[k]);
      chk($sformatf("s1_o2_%0d", k), dac2, s1_o2[k]);
      if (k == 0) chk("s1_smpl", smpl1, 512);
      if (k == 1) chk("s1_i1", u1.i1, -512);
    end
    cnt1 = 0; cnt2 = 0;
    repeat (1024) begin
      tick();
      cnt1 += int'(dac1);
      cnt2 += int'(dac2);
    end
    chk("s1_cnt_o1", cnt1, 512);
    chk("s1_cnt_o2", cnt2, 512);
    chk("s1_ovf1", ovf1, 0);
    chk("s1_ovf2", ovf2, 0);
    // One-cycle reset mid-stream, then the mid-scale sequence must replay exactly.
    xrst = 1'b0;
    tick();
    chk("mid_rst_smpl", smpl2, 0);
    chk("mid_rst_i1", u1.i1, 0);
    chk("mid_rst_dac", dac1, 0);
    chk("mid_rst_lfsr", u1.lfsr, 16'hACE1);
    xrst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("s5_o1_%0d", k), dac1, s1_o1[k]);
      chk($sformatf("s5_o2_%0d", k), dac2, s1_o2[k]);
    end
    // Capture 0: integrator moves one edge later, DAC bit departs from the pattern two edges later.
    video = 10'd0;
    tick();
    chk("lat_smpl0", smpl1, 0);
    chk("lat_i1_e0", u1.i1, 0);
    chk("lat_dac_e0", dac1, 1);
    ck_ee = 1'b0; video = 10'd1023;
    tick();
    chk("lat_i1_e1", u1.i1, -1024);
    chk("lat_dac_e1", dac1, 0);
    tick();
    chk("lat_dac_e2", dac1, 0);
    chk("hold_smpl_a", smpl1, 0);
    tick();
    chk("hold_smpl_b", smpl1, 0);
    chk("zero_i1_bounded", u1.i1, -1024);
    ck_ee = 1'b1;
    tick();
    chk("cap_smpl", smpl1, 1023);
    chk("cap_dac_e0", dac1, 0);
    ck_ee = 1'b0;
    tick();
    chk("cap_i1_e1", u1.i1, -1);
    chk("cap_dac_e1", dac1, 0);
    tick();
    chk("cap_i1_e2", u1.i1, 1022);
    chk("cap_dac_e2", dac1, 1);
    // Full-scale density with a 1-of-4 capture enable.
    cnt1 = 0;
    for (int k = 0; k < 1024; k++) begin
      ck_ee = (k % 4) == 0;
      tick();
      cnt1 += int'(dac1);
    end
    chk("fs_smpl_held", smpl1, 1023);
    chk("fs_cnt_o1", (cnt1 >= 1021 && cnt1 <= 1025) ? 1 : 0, 1);
    chk("fs_ovf1", ovf1, 0);
    // Pedestal level 205: density 205/1024.
    xrst = 1'b0; ck_ee = 1'b1;
    tick();
    xrst = 1'b1; video = 10'd205;
    repeat (64) tick();
    cnt1 = 0; cnt2 = 0;
    repeat (4096) begin
      tick();
      cnt1 += int'(dac1);
      cnt2 += int'(dac2);
    end
    chk("ped_cnt_o1", (cnt1 >= 818 && cnt1 <= 822) ? 1 : 0, 1);
    chk("ped_cnt_o2", (cnt2 >= 818 && cnt2 <= 824) ? 1 : 0, 1);
    chk("ped_ovf1", ovf1, 0);
    chk("ped_ovf2", ovf2, 0);
    // Sync-tip input 0: second-order I2 ramps down 512 per edge and clips on edge 65.
    xrst = 1'b0; video = 10'd0;
    tick();
    xrst = 1'b1;
    tick();
    chk("z_dac2_e1", dac2, 1);
    repeat (63) tick();
    chk("z_i2_e64", u2.i2, -32768);
    chk("z_ovf2_e64", ovf2, 0);
    chk("z_dac2_e64", dac2, 0);
    tick();
    chk("z_ovf2_e65", ovf2, 1);
    chk("z_i2_e65", u2.i2, -32768);
    chk("z_ovf1", ovf1, 0);
    chk("z_i1_o1", u1.i1, -1024);
    chk("z_dac1", dac1, 0);
    repeat (10) tick();
    chk("z_ovf2_sticky", ovf2, 1);
    chk("z_dac2_low", dac2, 0);
    // Clear together with a capture: both take effect.
    clr = 1'b1; ck_ee = 1'b1; video = 10'd300;
    tick();
    chk("clr_ovf2", ovf2, 0);
    chk("clr_i1", u2.i1, 0);
    chk("clr_i2", u2.i2, 0);
    chk("clr_dac2", dac2, 0);
    chk("clr_smpl", smpl2, 300);
    clr = 1'b0; ck_ee = 1'b0; video = 10'd0;
    tick();
    chk("post_clr_i1", u2.i1, 300);
    chk("post_clr_i2", u2.i2, 812);
    chk("post_clr_dac2", dac2, 1);
    chk("post_clr_smpl", smpl2, 300);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
